// File: rtl/fx_pkg.sv
// fx_pkg: shared types, constants and helpers for the fixed-point
// accumulator datapath.
//   fx_t        signed Q(FX_INT_W).(FX_FRAC_W) word at the default width
//   FX_MAX/MIN  saturation limits of fx_t
//   ovf_detect  signed-add overflow from operand and result sign bits
package fx_pkg;

  localparam int FX_INT_W    = 16;
  localparam int FX_FRAC_W   = 16;
  localparam int FX_W        = FX_INT_W + FX_FRAC_W;
  localparam int FX_CHANNELS = 4;

  typedef logic signed [FX_W-1:0] fx_t;

  localparam fx_t FX_MAX = {1'b0, {(FX_W-1){1'b1}}};
  localparam fx_t FX_MIN = {1'b1, {(FX_W-1){1'b0}}};

  // Overflow occurs only when both operands share a sign and the result does not.
  function automatic logic ovf_detect(input logic a_sign, input logic b_sign,
                                      input logic r_sign);
    return (a_sign == b_sign) && (r_sign != a_sign);
  endfunction

endpackage

// File: rtl/fx_half_add.sv
// fx_half_add: N-bit unsigned adder with carry-in and carry-out, used for
// both halves of the split accumulator add.
//   a, b  N-bit addends
//   cin   carry into bit 0
//   sum   N-bit sum
//   cout  carry out of bit N-1
module fx_half_add #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
  end

  assign sum  = total[N-1:0];
  assign cout = total[N];

endmodule

// File: rtl/fx_accum_pipe.sv
// fx_accum_pipe: pipelined multi-channel signed fixed-point accumulator.
// S1 reads the channel's running sum and adds the fractional halves; S2 adds
// the integer halves with the registered carry, detects overflow, optionally
// saturates, writes the sum back and loads the output register.
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            input handshake
//   in_ch, in_clear, in_data     channel, start-new-sum flag, Q sample
//   out_valid/out_ready          output handshake
//   out_ch, out_data, out_ovf    channel, new sum, overflow flag
module fx_accum_pipe
  import fx_pkg::*;
#(
  parameter int INT_W    = FX_INT_W,
  parameter int FRAC_W   = FX_FRAC_W,
  parameter int CHANNELS = FX_CHANNELS,
  parameter bit SATURATE = 1'b1,
  parameter int W        = INT_W + FRAC_W,
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_ch,
  input  logic          in_clear,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_ch,
  output logic [W-1:0]  out_data,
  output logic          out_ovf
);

  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  // S1 stage
  logic              s1_valid_q, s1_valid_d;
  logic [W-1:0]      s1_data_q,  s1_data_d;
  logic [CW-1:0]     s1_ch_q,    s1_ch_d;
  logic              s1_clear_q, s1_clear_d;

  // S2 stage
  logic              s2_valid_q, s2_valid_d;
  logic [CW-1:0]     s2_ch_q,    s2_ch_d;
  logic [FRAC_W-1:0] s2_frac_q,  s2_frac_d;
  logic              s2_carry_q, s2_carry_d;
  logic [INT_W-1:0]  s2_int_a_q, s2_int_a_d;
  logic [INT_W-1:0]  s2_int_b_q, s2_int_b_d;

  // Output register
  logic              out_valid_q, out_valid_d;
  logic [CW-1:0]     out_ch_q,    out_ch_d;
  logic [W-1:0]      out_data_q,  out_data_d;
  logic              out_ovf_q,   out_ovf_d;

  // Accumulator bank kept in flops so reset clears every channel at once
  logic [W-1:0]      acc_q [CHANNELS];
  logic [W-1:0]      acc_d [CHANNELS];

  // Datapath and control nets
  logic              ch_ok;
  logic [W-1:0]      acc_rd;
  logic [FRAC_W-1:0] frac_sum;
  logic              frac_carry;
  logic [INT_W-1:0]  int_sum;
  logic              int_cout_unused;
  logic              ovf;
  logic [W-1:0]      result;
  logic              out_free, s2_adv, s2_can_load, hazard, s1_adv, accept;

  // Beats to channels outside the bank are accepted and silently dropped.
  always_comb begin
    ch_ok = (32'(in_ch) < 32'(CHANNELS));
  end

  always_comb begin
    acc_rd = s1_clear_q ? '0 : acc_q[s1_ch_q];
  end

  fx_half_add #(.N(FRAC_W)) u_frac_add (
    .a    (s1_data_q[FRAC_W-1:0]),
    .b    (acc_rd[FRAC_W-1:0]),
    .cin  (1'b0),
    .sum  (frac_sum),
    .cout (frac_carry)
  );

  // The integer carry-out is not needed: overflow is judged from the signs.
  fx_half_add #(.N(INT_W)) u_int_add (
    .a    (s2_int_a_q),
    .b    (s2_int_b_q),
    .cin  (s2_carry_q),
    .sum  (int_sum),
    .cout (int_cout_unused)
  );

  // On saturation the clamp direction follows the common operand sign.
  always_comb begin
    ovf    = ovf_detect(s2_int_a_q[INT_W-1], s2_int_b_q[INT_W-1], int_sum[INT_W-1]);
    result = {int_sum, s2_frac_q};
    if (SATURATE && ovf) begin
      result = s2_int_a_q[INT_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

  // S1 may not read a channel whose update is still sitting in S2, even if S2
  // writes it this edge, because the read would see the stale sum. A clearing
  // beat ignores the stored sum, so it can follow straight behind; the write
  // order is still kept since it reaches S2 only after the older beat leaves.
  always_comb begin
    out_free    = !out_valid_q || out_ready;
    s2_adv      = s2_valid_q && out_free;
    s2_can_load = !s2_valid_q || s2_adv;
    hazard      = s1_valid_q && !s1_clear_q && s2_valid_q && (s2_ch_q == s1_ch_q);
    s1_adv      = s1_valid_q && s2_can_load && !hazard;
    in_ready    = !rst && (!s1_valid_q || s1_adv);
    accept      = in_valid && in_ready;
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_ch_d     = s1_ch_q;
    s1_clear_d  = s1_clear_q;
    s2_valid_d  = s2_valid_q;
    s2_ch_d     = s2_ch_q;
    s2_frac_d   = s2_frac_q;
    s2_carry_d  = s2_carry_q;
    s2_int_a_d  = s2_int_a_q;
    s2_int_b_d  = s2_int_b_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    acc_d       = acc_q;

    if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    if (accept) begin
      s1_valid_d = ch_ok;
      s1_data_d  = in_data;
      s1_ch_d    = in_ch;
      s1_clear_d = in_clear;
    end

    if (s2_adv) begin
      s2_valid_d = 1'b0;
    end
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_ch_d    = s1_ch_q;
      s2_frac_d  = frac_sum;
      s2_carry_d = frac_carry;
      s2_int_a_d = s1_data_q[W-1:FRAC_W];
      s2_int_b_d = acc_rd[W-1:FRAC_W];
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (s2_adv) begin
      out_valid_d      = 1'b1;
      out_ch_d         = s2_ch_q;
      out_data_d       = result;
      out_ovf_d        = ovf;
      acc_d[s2_ch_q]   = result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_ch_q     <= '0;
      s1_clear_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_ch_q     <= '0;
      s2_frac_q   <= '0;
      s2_carry_q  <= 1'b0;
      s2_int_a_q  <= '0;
      s2_int_b_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_ch_q     <= s1_ch_d;
      s1_clear_q  <= s1_clear_d;
      s2_valid_q  <= s2_valid_d;
      s2_ch_q     <= s2_ch_d;
      s2_frac_q   <= s2_frac_d;
      s2_carry_q  <= s2_carry_d;
      s2_int_a_q  <= s2_int_a_d;
      s2_int_b_q  <= s2_int_b_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule
